// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the write-back data cache.
package dcache_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_OFF_W     = 2;
    localparam int DEF_SETS       = 16;
    localparam int DEF_WAYS       = 2;
    localparam int DEF_LINE_WORDS = 4;

    // RISC-V funct3 load/store size codes.
    typedef enum logic [2:0] {
        AC_B  = 3'b000,
        AC_H  = 3'b001,
        AC_W  = 3'b010,
        AC_BU = 3'b100,
        AC_HU = 3'b101
    } addr_ctrl_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL
    } dc_state_t;

    // Byte enables plus lane-replicated data for a store.
    typedef struct packed {
        logic [3:0]        be;
        logic [WORD_W-1:0] data;
    } st_align_t;

    // Width of the word-offset field; zero when a line holds one word.
    function automatic int word_off_w(input int line_words);
        return (line_words > 1) ? $clog2(line_words) : 0;
    endfunction

    // Width of the set-index field.
    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

endpackage

// File: rtl/dcache_wb_ls_align.sv
// Load extract/extend and store byte-enable/replicate for one 32-bit word.
module dcache_wb_ls_align
    import dcache_pkg::*;
(
    input  logic [2:0]  addr_ctrl,
    input  logic [1:0]  byte_off,
    input  logic [31:0] load_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [3:0]  store_be,
    output logic [31:0] store_wdata
);

    // Halfword accesses use byte_off[1] only; word accesses ignore byte_off.
    function automatic logic [31:0] load_extract(input logic [2:0] ac,
                                                 input logic [1:0] off,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (ac)
            AC_B:    return {{24{b[7]}}, b};
            AC_BU:   return {24'h0, b};
            AC_H:    return {{16{h[15]}}, h};
            AC_HU:   return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic st_align_t store_align(input logic [2:0] ac,
                                              input logic [1:0] off,
                                              input logic [31:0] d);
        st_align_t s;
        case (ac)
            AC_B, AC_BU: begin
                s.be   = 4'b0001 << off;
                s.data = {4{d[7:0]}};
            end
            AC_H, AC_HU: begin
                s.be   = off[1] ? 4'b1100 : 4'b0011;
                s.data = {2{d[15:0]}};
            end
            default: begin
                s.be   = 4'b1111;
                s.data = d;
            end
        endcase
        return s;
    endfunction

    st_align_t st;

    // Both directions are pure functions of the current request.
    always_comb begin
        load_data = load_extract(addr_ctrl, byte_off, load_word);
        st        = store_align(addr_ctrl, byte_off, store_data);
    end

    assign store_be    = st.be;
    assign store_wdata = st.data;

endmodule

// File: rtl/dcache_wb.sv
// Write-back, write-allocate data cache with line-wide miss port.
module dcache_wb
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int SETS       = DEF_SETS,
    parameter int WAYS       = DEF_WAYS,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     WE,
    input  logic                     RE,
    input  logic [ADDR_WIDTH-1:0]    A,
    input  logic [31:0]              WD,
    input  logic [2:0]               AddressingControl,
    output logic [31:0]              RD,
    output logic                     stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    output logic [32*LINE_WORDS-1:0] mem_wdata,
    input  logic                     mem_ready,
    input  logic [32*LINE_WORDS-1:0] mem_rdata
);

    localparam int WO_W      = word_off_w(LINE_WORDS);
    localparam int WO_BITS   = (WO_W > 0) ? WO_W : 1;
    localparam int IDX_W     = index_w(SETS);
    localparam int OFF_W     = BYTE_OFF_W + WO_W;
    localparam int TAG_W     = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int WAY_W     = 1;
    localparam int LINE_BITS = WORD_W * LINE_WORDS;

    // Line state: valid/dirty per way as set-wide vectors, LRU per set.
    logic [SETS-1:0]      valid_q [WAYS];
    logic [SETS-1:0]      valid_d [WAYS];
    logic [SETS-1:0]      dirty_q [WAYS];
    logic [SETS-1:0]      dirty_d [WAYS];
    logic [SETS-1:0]      lru_q, lru_d;
    logic [TAG_W-1:0]     tag_q   [WAYS][SETS];
    logic [TAG_W-1:0]     tag_d   [WAYS][SETS];
    logic [LINE_BITS-1:0] data_q  [WAYS][SETS];
    logic [LINE_BITS-1:0] data_d  [WAYS][SETS];

    // Miss context is latched so the transfer survives the pipeline letting go.
    dc_state_t            state_q, state_d;
    logic [WAY_W-1:0]     victim_q, victim_d;
    logic [IDX_W-1:0]     req_idx_q, req_idx_d;
    logic [TAG_W-1:0]     req_tag_q, req_tag_d;

    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     tag;
    logic [WO_BITS-1:0]   word_sel;
    logic                 hit;
    logic [WAY_W-1:0]     hit_way;
    logic [WAY_W-1:0]     victim_way;
    logic                 lookup_ok;
    logic [LINE_BITS-1:0] hit_line;
    logic [LINE_BITS-1:0] merged_line;
    logic [31:0]          hit_word;
    logic [31:0]          merged_word;
    logic [31:0]          load_data;
    logic [3:0]           store_be;
    logic [31:0]          store_wdata;

    function automatic logic [ADDR_WIDTH-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                        input logic [IDX_W-1:0] i);
        return (ADDR_WIDTH'(t) << (OFF_W + IDX_W)) | (ADDR_WIDTH'(i) << OFF_W);
    endfunction

    assign idx      = IDX_W'(A >> OFF_W);
    assign tag      = TAG_W'(A >> (OFF_W + IDX_W));
    assign word_sel = WO_BITS'((A >> BYTE_OFF_W) & ADDR_WIDTH'(LINE_WORDS - 1));

    // Tag compare across the set; first matching valid way wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[w][idx] && tag_q[w][idx] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: first invalid way, else the LRU way; direct-mapped always way 0.
    always_comb begin
        victim_way = '0;
        if (WAYS > 1) begin
            if (!valid_q[0][idx])
                victim_way = '0;
            else if (!valid_q[WAYS-1][idx])
                victim_way = WAY_W'(WAYS - 1);
            else
                victim_way = lru_q[idx];
        end
    end

    assign lookup_ok = (state_q == IDLE) && hit;
    assign hit_line  = data_q[hit_way][idx];
    assign hit_word  = hit_line[{word_sel, 5'b00000} +: 32];

    dcache_wb_ls_align u_align (
        .addr_ctrl   (AddressingControl),
        .byte_off    (A[1:0]),
        .load_word   (hit_word),
        .store_data  (WD),
        .load_data   (load_data),
        .store_be    (store_be),
        .store_wdata (store_wdata)
    );

    // Byte-enabled merge of the store into the hit line.
    always_comb begin
        merged_word = hit_word;
        for (int b = 0; b < 4; b++) begin
            if (store_be[b])
                merged_word[b*8 +: 8] = store_wdata[b*8 +: 8];
        end
        merged_line = hit_line;
        merged_line[{word_sel, 5'b00000} +: 32] = merged_word;
    end

    assign RD    = (RE && lookup_ok) ? load_data : 32'h0;
    assign stall = (WE || RE) && !lookup_ok;

    // Next-state, array updates and memory-port outputs for the miss FSM.
    always_comb begin
        state_d   = state_q;
        victim_d  = victim_q;
        req_idx_d = req_idx_q;
        req_tag_d = req_tag_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        lru_d     = lru_q;
        tag_d     = tag_q;
        data_d    = data_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        unique case (state_q)
            IDLE: begin
                if ((WE || RE) && hit) begin
                    lru_d[idx] = (hit_way == '0);
                    if (WE) begin
                        data_d[hit_way][idx]  = merged_line;
                        dirty_d[hit_way][idx] = 1'b1;
                    end
                end else if (WE || RE) begin
                    victim_d  = victim_way;
                    req_idx_d = idx;
                    req_tag_d = tag;
                    if (valid_q[victim_way][idx] && dirty_q[victim_way][idx])
                        state_d = WRITEBACK;
                    else
                        state_d = REFILL;
                end
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = line_addr(tag_q[victim_q][req_idx_q], req_idx_q);
                mem_wdata = data_q[victim_q][req_idx_q];
                if (mem_ready) begin
                    dirty_d[victim_q][req_idx_q] = 1'b0;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = line_addr(req_tag_q, req_idx_q);
                if (mem_ready) begin
                    data_d[victim_q][req_idx_q]  = mem_rdata;
                    tag_d[victim_q][req_idx_q]   = req_tag_q;
                    valid_d[victim_q][req_idx_q] = 1'b1;
                    dirty_d[victim_q][req_idx_q] = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and line status bits, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q   <= IDLE;
            victim_q  <= '0;
            req_idx_q <= '0;
            req_tag_q <= '0;
            lru_q     <= '0;
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
        end else begin
            state_q   <= state_d;
            victim_q  <= victim_d;
            req_idx_q <= req_idx_d;
            req_tag_q <= req_tag_d;
            lru_q     <= lru_d;
            valid_q   <= valid_d;
            dirty_q   <= dirty_d;
        end
    end

    // Tag and data storage.
    always_ff @(posedge clk) begin
        // NOTE: tag/data arrays have no reset; valid bits gate every use, so they map to plain RAM.
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_dcache_wb.sv
// Directed self-checking bench for dcache_wb (2-way and direct-mapped).
module tb_dcache_wb;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    // 2-way instance
    logic         WE = 1'b0, RE = 1'b0;
    logic [31:0]  A = '0, WD = '0;
    logic [2:0]   AC = 3'b010;
    logic [31:0]  RD;
    logic         stall, mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready = 1'b1;
    logic [127:0] mem_rdata = '0;

    // direct-mapped instance
    logic         WE1 = 1'b0, RE1 = 1'b0;
    logic [31:0]  A1 = '0, WD1 = '0;
    logic [2:0]   AC1 = 3'b010;
    logic [31:0]  RD1;
    logic         stall1, mem_req1, mem_we1;
    logic [31:0]  mem_addr1;
    logic [127:0] mem_wdata1;
    logic         mem_ready1 = 1'b1;
    logic [127:0] mem_rdata1 = '0;

    int n_checks = 0;
    int n_errs   = 0;

    // backing memory bookkeeping
    logic [127:0] store [logic [31:0]];
    int           hold_target = 0;
    int           wait_cnt = 0;
    int           fetch_cnt = 0, wb_cnt = 0;
    logic [31:0]  fetch_addr = '0, wb_addr = '0;
    logic [127:0] wb_data = '0;
    int           addr_moves = 0;
    logic         prev_req = 1'b0, prev_done = 1'b0;
    logic [31:0]  prev_addr = '0;
    int           fetch1_cnt = 0, wb1_cnt = 0;

    dcache_wb #(.ADDR_WIDTH(32), .SETS(16), .WAYS(2), .LINE_WORDS(4)) dut (
        .clk(clk), .rst(rst), .WE(WE), .RE(RE), .A(A), .WD(WD),
        .AddressingControl(AC), .RD(RD), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    dcache_wb #(.ADDR_WIDTH(32), .SETS(16), .WAYS(1), .LINE_WORDS(4)) dut1 (
        .clk(clk), .rst(rst), .WE(WE1), .RE(RE1), .A(A1), .WD(WD1),
        .AddressingControl(AC1), .RD(RD1), .stall(stall1),
        .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_ready(mem_ready1), .mem_rdata(mem_rdata1)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] pattern(input logic [31:0] la);
        logic [127:0] l;
        for (int i = 0; i < 4; i++)
            l[i*32 +: 32] = 32'hA500_0000 | la | 32'(i);
        if (la == 32'h100)
            l = {32'h99AABBCC, 32'h55667788, 32'h11223344, 32'hDEADBEEF};
        return l;
    endfunction

    function automatic logic [127:0] line_data(input logic [31:0] la);
        if (store.exists(la))
            return store[la];
        return pattern(la);
    endfunction

    // Memory model for the 2-way instance: decide ready and data at negedge,
    // log the transaction that will complete on the coming rising edge.
    always @(negedge clk) begin
        if (!mem_req)
            wait_cnt = 0;
        if (mem_req && wait_cnt < hold_target) begin
            mem_ready = 1'b0;
            wait_cnt++;
        end else begin
            mem_ready = 1'b1;
        end
        mem_rdata = line_data(mem_addr);
        if (mem_req && prev_req && !prev_done && mem_addr != prev_addr)
            addr_moves++;
        prev_req  = mem_req;
        prev_addr = mem_addr;
        prev_done = mem_req && mem_ready;
        if (mem_req && mem_ready) begin
            wait_cnt = 0;
            if (mem_we) begin
                wb_cnt++;
                wb_addr   = mem_addr;
                wb_data   = mem_wdata;
                store[mem_addr] = mem_wdata;
            end else begin
                fetch_cnt++;
                fetch_addr = mem_addr;
            end
        end
    end

    // Memory model for the direct-mapped instance (always ready).
    always @(negedge clk) begin
        mem_rdata1 = pattern(mem_addr1);
        if (mem_req1) begin
            if (mem_we1) wb1_cnt++;
            else         fetch1_cnt++;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One access on the 2-way cache; entered and left at posedge+1.
    task automatic access(input logic we_i, input logic re_i, input logic [31:0] a_i,
                          input logic [31:0] wd_i, input logic [2:0] ac_i,
                          output logic [31:0] rd_o, output int stalls);
        WE = we_i; RE = re_i; A = a_i; WD = wd_i; AC = ac_i;
        stalls = 0;
        rd_o   = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!stall) begin
                rd_o = RD;
                break;
            end
            stalls++;
        end
        @(posedge clk); #1;
        WE = 1'b0; RE = 1'b0;
    endtask

    task automatic access1(input logic [31:0] a_i, output logic [31:0] rd_o, output int stalls);
        RE1 = 1'b1; A1 = a_i; AC1 = 3'b010;
        stalls = 0;
        rd_o   = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!stall1) begin
                rd_o = RD1;
                break;
            end
            stalls++;
        end
        @(posedge clk); #1;
        RE1 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int          st;
        int          f0, w0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall",     stall,     1'b0);
        check("rst_mem_req",   mem_req,   1'b0);
        check("rst_mem_we",    mem_we,    1'b0);
        check("rst_mem_addr",  mem_addr,  32'h0);
        check("rst_mem_wdata", mem_wdata, 128'h0);
        check("rst_rd",        RD,        32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Clean miss then hit
        access(1'b0, 1'b1, 32'h100, 32'h0, 3'b010, rd, st);
        check("miss_stall",  st, 2);
        check("miss_rd",     rd, 32'hDEADBEEF);
        check("miss_fetchn", fetch_cnt, 1);
        check("miss_faddr",  fetch_addr, 32'h100);
        check("miss_wbn",    wb_cnt, 0);
        access(1'b0, 1'b1, 32'h100, 32'h0, 3'b010, rd, st);
        check("hit_stall", st, 0);
        check("hit_rd",    rd, 32'hDEADBEEF);

        // Load extraction
        access(1'b0, 1'b1, 32'h103, 32'h0, 3'b000, rd, st);
        check("lb_103",  rd, 32'hFFFFFFDE);
        access(1'b0, 1'b1, 32'h103, 32'h0, 3'b100, rd, st);
        check("lbu_103", rd, 32'h000000DE);
        access(1'b0, 1'b1, 32'h102, 32'h0, 3'b001, rd, st);
        check("lh_102",  rd, 32'hFFFFDEAD);
        access(1'b0, 1'b1, 32'h102, 32'h0, 3'b101, rd, st);
        check("lhu_102", rd, 32'h0000DEAD);
        access(1'b0, 1'b1, 32'h100, 32'h0, 3'b000, rd, st);
        check("lb_100",  rd, 32'hFFFFFFEF);
        access(1'b0, 1'b1, 32'h103, 32'h0, 3'b001, rd, st);
        check("lh_mis",  rd, 32'hFFFFDEAD);
        access(1'b0, 1'b1, 32'h107, 32'h0, 3'b010, rd, st);
        check("lw_mis",  rd, 32'h11223344);
        check("lw_mis_stall", st, 0);

        // Sub-word stores and store+load
        access(1'b1, 1'b0, 32'h101, 32'h12345655, 3'b000, rd, st);
        check("sb_stall", st, 0);
        access(1'b0, 1'b1, 32'h100, 32'h0, 3'b010, rd, st);
        check("sb_merge", rd, 32'hDEAD55EF);
        access(1'b1, 1'b0, 32'h10A, 32'hABCD9876, 3'b001, rd, st);
        access(1'b0, 1'b1, 32'h108, 32'h0, 3'b010, rd, st);
        check("sh_merge", rd, 32'h98767788);
        access(1'b1, 1'b1, 32'h10C, 32'hCAFEF00D, 3'b010, rd, st);
        check("we_re_pre", rd, 32'h99AABBCC);
        access(1'b0, 1'b1, 32'h10C, 32'h0, 3'b010, rd, st);
        check("we_re_post", rd, 32'hCAFEF00D);

        // Second way fills clean
        access(1'b1, 1'b0, 32'h200, 32'h0BADF00D, 3'b010, rd, st);
        check("sw200_stall", st, 2);
        check("sw200_faddr", fetch_addr, 32'h200);
        check("sw200_wbn",   wb_cnt, 0);

        // Dirty LRU victim written back
        access(1'b0, 1'b1, 32'h300, 32'h0, 3'b010, rd, st);
        check("dirty_stall", st, 3);
        check("dirty_wbn",   wb_cnt, 1);
        check("dirty_waddr", wb_addr, 32'h100);
        check("dirty_wdata", wb_data, {32'hCAFEF00D, 32'h98767788, 32'h11223344, 32'hDEAD55EF});
        check("dirty_faddr", fetch_addr, 32'h300);
        check("dirty_rd",    rd, 32'hA5000300);

        // LRU now points at way holding 0x200
        access(1'b0, 1'b1, 32'h100, 32'h0, 3'b010, rd, st);
        check("lru_stall", st, 3);
        check("lru_waddr", wb_addr, 32'h200);
        check("lru_wdata", wb_data, {32'hA5000203, 32'hA5000202, 32'hA5000201, 32'h0BADF00D});
        check("lru_rd",    rd, 32'hDEAD55EF);

        // Memory wait during refill
        hold_target = 5;
        addr_moves  = 0;
        access(1'b0, 1'b1, 32'h500, 32'h0, 3'b010, rd, st);
        hold_target = 0;
        check("wait_stall", st, 7);
        check("wait_moves", addr_moves, 0);
        check("wait_faddr", fetch_addr, 32'h500);
        check("wait_rd",    rd, 32'hA5000500);

        // Reset in the middle of a refill
        hold_target = 10;
        RE = 1'b1; A = 32'h400; AC = 3'b010;
        @(negedge clk);
        check("rr_idle_req", mem_req, 1'b0);
        @(posedge clk); #1;
        check("rr_req",  mem_req, 1'b1);
        check("rr_addr", mem_addr, 32'h400);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("rr_drop", mem_req, 1'b0);
        RE = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        hold_target = 0;
        @(posedge clk); #1;
        f0 = fetch_cnt;
        access(1'b0, 1'b1, 32'h400, 32'h0, 3'b010, rd, st);
        check("rr_remiss", st, 2);
        check("rr_fetch",  fetch_cnt - f0, 1);
        check("rr_rd",     rd, 32'hA5000400);

        // Direct-mapped: conflicting loads always miss, no writebacks
        f0 = fetch1_cnt;
        w0 = wb1_cnt;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            logic [31:0] exp;
            a   = (i % 2 == 0) ? 32'h100 : 32'h200;
            exp = (i % 2 == 0) ? 32'hDEADBEEF : 32'hA5000200;
            access1(a, rd, st);
            check("dm_stall", st, 2);
            check("dm_rd",    rd, exp);
        end
        check("dm_fetchn", fetch1_cnt - f0, 4);
        check("dm_wbn",    wb1_cnt - w0, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/dcache_wb.md
# dcache_wb

Parametrised, write-back, write-allocate data cache for the memory stage. It replaces the flat data memory behind the stage wrapper, and drives a real `stall` output that freezes the pipeline on a miss. Loads and stores are byte, half or word wide, selected by the RISC-V funct3 `AddressingControl` code. Misses are serviced over a line-wide request/ready port to backing memory.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: byte address width.
- `SETS`, default 16: number of sets; must be a power of two, at least 2.
- `WAYS`, default 2: associativity; 1 or 2 only.
- `LINE_WORDS`, default 4: 32-bit words per line; must be a power of two.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `WE` in 1: store request.
- `RE` in 1: load request.
- `A` in ADDR_WIDTH: byte address.
- `WD` in 32: store data; the low byte/half is used for sub-word stores.
- `AddressingControl` in 3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `RD` out 32: load data, sign- or zero-extended per `AddressingControl`.
- `stall` out 1: the access is not complete this cycle.
- `mem_req` out 1: backing-memory transaction request.
- `mem_we` out 1: 1 = line writeback, 0 = line fetch.
- `mem_addr` out ADDR_WIDTH: line-aligned address.
- `mem_wdata` out 32*LINE_WORDS: victim line.
- `mem_ready` in 1: transaction completes on a cycle where `mem_req && mem_ready`.
- `mem_rdata` in 32*LINE_WORDS: fetched line; sampled on completion.

## Operation
- Address split, LSB first: byte offset (2 bits), word offset (log2 LINE_WORDS), index (log2 SETS), tag (the remaining bits).
- Per-line state: valid, dirty, tag, data. Per-set state: one LRU bit, used only when WAYS=2.
- Misaligned addresses are aligned down: halfword accesses ignore A[0]; word accesses ignore A[1:0].
- Hit: a valid way in the set has a matching tag. Lookup is combinational.
- Load hit: `RD` is valid in the same cycle.
- Store hit: the byte-enabled merge into the line happens at the clock edge, and the line's dirty bit is set.
- Any hit sets LRU to point at the other way.
- If `WE` and `RE` are both high, the access is treated as a store. `RD` still shows the pre-store data.
- `RD` = 0 when `RE` is low or the access misses.
- Victim selection: the first invalid way (way 0 first); otherwise the LRU way.
- FSM states:
  - IDLE: on a miss, go to WRITEBACK if the victim is valid and dirty, else go to REFILL.
  - WRITEBACK: `mem_req`=1, `mem_we`=1, `mem_addr` = {victim tag, index, 0}. On completion, clear the victim's dirty bit and go to REFILL.
  - REFILL: `mem_req`=1, `mem_we`=0, `mem_addr` = {request tag, index, 0}. On completion, write the line, set valid=1, dirty=0, write the tag, and go to IDLE.
- After a refill, the held request is re-looked-up in IDLE. It now hits and completes normally; a pending store merges on that cycle.
- `stall` = (`WE`|`RE`) && !(state==IDLE && hit). It is combinational. The pipeline holds `A`, `WD`, `WE`, `RE` and `AddressingControl` stable while `stall` is high.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are held stable until completion.

## Timing
- Reset (asynchronous, takes effect immediately):
  - all valid, dirty and LRU bits cleared; FSM to IDLE;
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `RD`=0, `stall`=0.
- Reset during WRITEBACK or REFILL abandons the transaction: `mem_req` drops in the same cycle and dirty data is lost.
- Hit: 0 extra cycles.
- Clean miss: 1 (IDLE→REFILL) + N memory-wait cycles + 1 (re-lookup). With `mem_ready` tied high, `stall` is high for exactly 2 cycles.
- Dirty miss: adds 1 + M cycles for the writeback. With `mem_ready` tied high, `stall` is high for 3 cycles.
- The pipeline dropping `WE`/`RE` during a miss does not abort the line transfer; the line still installs.

## Structure
- Shared package `dcache_pkg`:
  - `addr_ctrl_t` enum of the five funct3 codes;
  - `dc_state_t` {IDLE, WRITEBACK, REFILL};
  - localparam widths derived from SETS and LINE_WORDS.
- Sub-module `ls_align`: purely combinational. Two functions:
  - load extract plus sign/zero extension from a 32-bit word;
  - store byte-enable and data-replicate generation from `AddressingControl` and A[1:0].
- Storage arrays and the FSM live in `dcache_wb`.

## Test plan
- Reset, then LW A=0x100 with `mem_rdata` word 0 = 0xDEADBEEF and `mem_ready`=1:
  - `stall` high 2 cycles; one fetch with `mem_addr`=0x100;
  - then `RD`=0xDEADBEEF; a repeat LW hits with `stall`=0.
- After that fill:
  - LB A=0x103 → `RD`=0xFFFFFFDE;
  - LBU A=0x103 → 0x000000DE;
  - LH A=0x102 → 0xFFFFDEAD;
  - SB WD=0x55 at 0x101, then LW 0x100 → 0xDEAD55EF.
- SETS=16, LINE_WORDS=4, WAYS=2 (conflict addresses 0x100, 0x200, 0x300):
  - SW 0x100 and 0x200 (both miss, both become dirty), then LW 0x300;
  - → writeback of the 0x100 line (the LRU way) with `mem_we`=1, then a fetch of 0x300;
  - `stall` high 3 cycles.
- `mem_ready` held low 5 cycles during REFILL:
  - `mem_req` and `mem_addr` stay stable; `stall` stays high for 7 cycles total.
- `rst` asserted mid-REFILL:
  - `mem_req` drops in the same cycle;
  - a subsequent LW of the same address misses again.
- WAYS=1: two conflicting loads alternate; every access misses and no writeback is issued while lines are clean.
